seg7_scan: RTL and testbench
============================

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4, SHALL set the number of multiplexed digits (legal range 1..8).
REQ-002 Parameter REFRESH_DIV, default 100000, SHALL set the clk cycles per digit slot (legal minimum BLANK_CYCLES+2).
REQ-003 Parameter BLANK_CYCLES, default 1000, SHALL set the anode-off cycles at the start of each slot (anti-ghosting).
REQ-004 Port clk, input, 1, SHALL be the single clock; all state SHALL be on its rising edge.
REQ-005 Port rst_n, input, 1, SHALL be the asynchronous, active-low reset.
REQ-006 Port enable, input, 1, SHALL enable scanning when high.
REQ-007 Port value, input, 4*NUM_DIGITS, SHALL hold hex nibbles; nibble k SHALL show on digit k, with digit 0 rightmost.
REQ-008 Port dp, input, NUM_DIGITS, SHALL hold the per-digit decimal point, active high.
REQ-009 Port load, input, 1, SHALL be a one-cycle strobe that captures value and dp into the pending register.
REQ-010 Port an, output, NUM_DIGITS, SHALL drive the active-low anodes.
REQ-011 Port out, output, 8, SHALL drive the active-low segments: bit7=dp, bits6..0=g,f,e,d,c,b,a.
REQ-012 Port frame_start, output, 1, SHALL pulse high for one cycle when digit 0's slot begins.

Function
REQ-013 The block SHALL keep three states: IDLE, BLANK and DRIVE.
REQ-014 IDLE SHALL hold an all-ones, out all-ones and the prescaler at 0; it SHALL go to BLANK with digit index 0 on the first cycle enable is high.
REQ-015 BLANK SHALL hold an all-ones with out already showing the current digit's pattern; it SHALL go to DRIVE after BLANK_CYCLES cycles.
REQ-016 DRIVE SHALL drive an low only at the current digit index.
REQ-017 DRIVE SHALL end when the prescaler reaches REFRESH_DIV-1; the index SHALL then advance and the state SHALL return to BLANK.
REQ-018 The digit index SHALL wrap from NUM_DIGITS-1 to 0.
REQ-019 At wrap, frame_start SHALL pulse and the pending register SHALL copy into the display register.
REQ-020 Display data SHALL change only at a frame boundary, so no frame mixes old and new data.
REQ-021 A load in the same cycle as the frame boundary SHALL be displayed in that frame; loads that cycle SHALL have priority.
REQ-022 Multiple loads within one frame SHALL keep the last value only.
REQ-023 Encoding SHALL map 0..F to patterns including 0=8'b11000000, 1=8'b11111001, 2=8'b10100100, 3=8'b10110000 and F=8'b10001110; a set dp SHALL clear bit 7.
REQ-024 Deasserting enable SHALL return the block to IDLE on the next cycle from any state; the pending register SHALL be kept.
REQ-025 an and out SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-026 Asserting rst_n low SHALL immediately force an and out to all-ones, frame_start to 0, state to IDLE, and index, prescaler, pending and display registers to 0.
REQ-027 After rst_n is released, the first scan SHALL start from digit 0 with BLANK, including when reset hit mid-slot.

Configuration
REQ-028 With macro SEG7_LZS_EN defined, leading-zero suppression SHALL apply: any digit above the most significant nonzero nibble, excluding digit 0, SHALL show segments off unless its dp is set.
REQ-029 Without SEG7_LZS_EN, every digit SHALL show its nibble.

Structure
REQ-030 Package seg7_pkg SHALL hold the state typedef, the 16-entry hex-to-segment constant table and the SEG_BLANK=8'hFF constant.
REQ-031 Encoding SHALL live in combinational sub-module seg7_encode (nibble, dp, blank -> 8-bit pattern).

Verification (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-032 Reset test: with enable=1, load 16'h0123 and no dp, the bench SHALL see digit 0 show 8'b10110000 (3), digit 1 show 10100100 (2), digit 2 show 11111001 (1) and digit 3 show 11000000 (0); each anode SHALL be low for 6 of every 8 cycles.
REQ-033 Tearing test: loading 16'hBEEF mid-frame SHALL leave the current frame showing 0123, and the next frame_start SHALL switch to BEEF on all four digits.
REQ-034 Enable test: dropping enable during DRIVE of digit 2 SHALL give an=4'hF the next cycle; re-enabling SHALL start at digit 0 in BLANK with frame_start=1.
REQ-035 Reset-mid-slot test: pulsing rst_n low during DRIVE SHALL immediately give an=4'hF and out=8'hFF, and the display SHALL show 0000 until a new load.
REQ-036 SEG7_LZS_EN test: with the macro defined, value=16'h0007 SHALL show only digit 0 lit (7); with dp=4'b0100 digit 2 SHALL show 8'b01111111.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scanner.
//   state_t   : scanner FSM states
//   SEG_TABLE : hex nibble -> active-low pattern {dp,g,f,e,d,c,b,a}, dp bit held off
//   SEG_BLANK : all segments and dp off
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Entry 0 is the rightmost byte.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E D C
    8'h83, 8'h88, 8'h90, 8'h80,   // B A 9 8
    8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
    8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
  };

endpackage

// File: rtl/seg7_encode.sv
// Combinational hex-to-segment encoder.
//   i_nibble : hex digit to show
//   i_dp     : decimal point request, active high
//   i_blank  : force all segments off (dp still honoured)
//   o_seg_c  : active-low pattern {dp,g,f,e,d,c,b,a}
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [7:0] o_seg_c
);

  always_comb begin
    o_seg_c = i_blank ? SEG_BLANK : SEG_TABLE[i_nibble];
    if (i_dp) o_seg_c[7] = 1'b0;
  end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed seven-segment display scanner with tear-free frame updates.
// Each digit slot lasts REFRESH_DIV cycles: BLANK_CYCLES with anodes off,
// then the rest with the slot's anode driven low.
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : scan while high; low returns to IDLE
//   value, dp   : hex nibbles and decimal points, digit 0 rightmost
//   load        : strobe capturing value/dp into the pending register
//   an, out     : active-low anodes and segments (registered)
//   frame_start : one-cycle pulse as digit 0's slot begins
// Optional build macro SEG7_LZS_EN enables leading-zero suppression.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              out,
  output logic                    frame_start
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [PRE_W-1:0]      r_presc;
  logic [VAL_W-1:0]      r_pend_val;
  logic [NUM_DIGITS-1:0] r_pend_dp;
  logic [VAL_W-1:0]      r_disp_val;
  logic [NUM_DIGITS-1:0] r_disp_dp;
  logic [NUM_DIGITS-1:0] r_an;
  logic [7:0]            r_out;
  logic                  r_frame;

  state_t                w_state_n;
  logic [IDX_W-1:0]      w_idx_n;
  logic [PRE_W-1:0]      w_presc_n;
  logic                  w_frame;
  logic [VAL_W-1:0]      w_pend_val_n;
  logic [NUM_DIGITS-1:0] w_pend_dp_n;
  logic [VAL_W-1:0]      w_disp_val_n;
  logic [NUM_DIGITS-1:0] w_disp_dp_n;
  logic [3:0]            w_nib;
  logic                  w_dp_bit;
  logic                  w_blank;
  logic [NUM_DIGITS-1:0] w_an_n;
  logic [7:0]            w_seg;
  logic [7:0]            w_out_n;

  // Slot sequencing: prescaler runs 0..REFRESH_DIV-1 across BLANK then DRIVE.
  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_presc_n = r_presc;
    w_frame   = 1'b0;
    if (!enable) begin
      w_state_n = IDLE;
      w_idx_n   = '0;
      w_presc_n = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_n = BLANK;
          w_idx_n   = '0;
          w_presc_n = '0;
          w_frame   = 1'b1;
        end
        BLANK: begin
          w_presc_n = r_presc + PRE_W'(1);
          if (r_presc == PRE_W'(BLANK_CYCLES - 1)) w_state_n = DRIVE;
        end
        DRIVE: begin
          if (r_presc == PRE_W'(REFRESH_DIV - 1)) begin
            w_presc_n = '0;
            w_state_n = BLANK;
            if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
              w_idx_n = '0;
              w_frame = 1'b1;
            end else begin
              w_idx_n = r_idx + IDX_W'(1);
            end
          end else begin
            w_presc_n = r_presc + PRE_W'(1);
          end
        end
        default: begin
          w_state_n = IDLE;
          w_idx_n   = '0;
          w_presc_n = '0;
        end
      endcase
    end
  end

  // A load coinciding with a frame boundary goes straight into the new frame.
  always_comb begin
    w_pend_val_n = load ? value : r_pend_val;
    w_pend_dp_n  = load ? dp    : r_pend_dp;
    w_disp_val_n = w_frame ? w_pend_val_n : r_disp_val;
    w_disp_dp_n  = w_frame ? w_pend_dp_n  : r_disp_dp;
  end

  // Select the upcoming digit's data so the registered outputs match the new slot.
  always_comb begin
    logic v_zero;
    w_nib    = 4'h0;
    w_dp_bit = 1'b0;
    w_blank  = 1'b0;
    w_an_n   = '1;
    v_zero   = 1'b1;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (w_idx_n == IDX_W'(k)) begin
        w_nib    = w_disp_val_n[4*k +: 4];
        w_dp_bit = w_disp_dp_n[k];
      end
      w_an_n[k] = !((w_state_n == DRIVE) && (w_idx_n == IDX_W'(k)));
    end
`ifdef SEG7_LZS_EN
    // Blank a digit when it and every nibble above it are zero; digit 0 always shows.
    for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
      v_zero = v_zero && (w_disp_val_n[4*k +: 4] == 4'h0);
      if (w_idx_n == IDX_W'(k)) w_blank = v_zero;
    end
`endif
  end

  seg7_encode u_encode (
    .i_nibble (w_nib),
    .i_dp     (w_dp_bit),
    .i_blank  (w_blank),
    .o_seg_c  (w_seg)
  );

  assign w_out_n = (w_state_n == IDLE) ? SEG_BLANK : w_seg;

  // State, data and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_presc    <= '0;
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_disp_val <= '0;
      r_disp_dp  <= '0;
      r_an       <= '1;
      r_out      <= SEG_BLANK;
      r_frame    <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_idx      <= w_idx_n;
      r_presc    <= w_presc_n;
      r_pend_val <= w_pend_val_n;
      r_pend_dp  <= w_pend_dp_n;
      r_disp_val <= w_disp_val_n;
      r_disp_dp  <= w_disp_dp_n;
      r_an       <= w_an_n;
      r_out      <= w_out_n;
      r_frame    <= w_frame;
    end
  end

  assign an          = r_an;
  assign out         = r_out;
  assign frame_start = r_frame;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
// Reference model tracks time since scan start and derives slot/digit/phase
// arithmetically; data latches on the modelled frame boundary.
module tb_seg7_scan;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  an;
  logic [7:0]  out;
  logic        frame_start;

  seg7_scan #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .value       (value),
    .dp          (dp),
    .load        (load),
    .an          (an),
    .out         (out),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int          n_vec;
  int          n_fail;
  int          lowcnt [4];
  logic [15:0] m_pend_val, m_disp_val;
  logic [3:0]  m_pend_dp, m_disp_dp;
  bit          m_active;
  int          m_t;
  logic [3:0]  e_an;
  logic [7:0]  e_out;
  logic        e_fs;

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [7:0] digit_pattern(input int d);
    logic [7:0] p;
    logic [3:0] nib;
    logic [15:0] v;
    v   = m_disp_val;
    nib = v[4*d +: 4];
    p   = hex_seg(nib);
`ifdef SEG7_LZS_EN
    if (d > 0 && (v >> (4 * d)) == 16'h0) p = 8'hFF;
`endif
    if (m_disp_dp[d]) p[7] = 1'b0;
    return p;
  endfunction

  task automatic model_reset();
    m_pend_val = '0; m_pend_dp = '0;
    m_disp_val = '0; m_disp_dp = '0;
    m_active   = 1'b0;
    m_t        = 0;
  endtask

  // Advance the model by one rising edge using the inputs presented to the DUT.
  task automatic model_edge();
    int ph, dg;
    if (load) begin
      m_pend_val = value;
      m_pend_dp  = dp;
    end
    if (!enable) begin
      m_active = 1'b0;
      e_an = 4'hF; e_out = 8'hFF; e_fs = 1'b0;
    end else begin
      if (!m_active) begin
        m_active = 1'b1;
        m_t = 0;
      end else begin
        m_t++;
      end
      ph   = m_t % RD;
      dg   = (m_t / RD) % ND;
      e_fs = (ph == 0 && dg == 0);
      if (e_fs) begin
        m_disp_val = m_pend_val;
        m_disp_dp  = m_pend_dp;
      end
      e_an = 4'hF;
      if (ph >= BC) e_an[dg] = 1'b0;
      e_out = digit_pattern(dg);
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("an", {4'h0, an}, {4'h0, e_an});
    check("out", out, e_out);
    check("frame_start", {7'h0, frame_start}, {7'h0, e_fs});
    for (int k = 0; k < ND; k++) if (an[k] === 1'b0) lowcnt[k]++;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      step();
      load = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    n_vec = 0; n_fail = 0;
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; value = '0; dp = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_an", {4'h0, an}, 8'h0F);
    check("reset_out", out, 8'hFF);
    check("reset_fs", {7'h0, frame_start}, 8'h00);

    // Scan 0123: load lands on the first frame boundary.
    rst_n = 1'b1; enable = 1'b1; load = 1'b1; value = 16'h0123; dp = 4'h0;
    foreach (lowcnt[k]) lowcnt[k] = 0;
    step();
    load = 1'b0;
    check("first_out", out, 8'hB0);
    cycles(31);
    for (int k = 0; k < ND; k++) check($sformatf("an_low_cycles_d%0d", k), 8'(lowcnt[k]), 8'd6);

    // Tearing: mid-frame load must wait for the next frame.
    cycles(12);
    value = 16'hBEEF; load = 1'b1;
    step();
    load = 1'b0;
    cycles(19);
    step();
    check("tear_fs", {7'h0, frame_start}, 8'h01);
    check("tear_out", out, 8'h8E);
    cycles(31);

    // Enable drop during DRIVE of digit 2.
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      step();
      if (m_active && (m_t % RD) >= BC + 1 && ((m_t / RD) % ND) == 2) found = 1'b1;
    end
    check("wait_drive_d2", {7'h0, found}, 8'h01);
    enable = 1'b0;
    step();
    check("en_drop_an", {4'h0, an}, 8'h0F);
    enable = 1'b1;
    step();
    check("reen_fs", {7'h0, frame_start}, 8'h01);
    check("reen_an", {4'h0, an}, 8'h0F);
    cycles(20);

    // Random loads, values, dp and rare enable drops.
    for (int i = 0; i < 300; i++) begin
      enable = ($urandom_range(0, 49) != 0);
      load   = ($urandom_range(0, 15) == 0);
      value  = 16'($urandom);
      dp     = 4'($urandom);
      step();
      load = 1'b0;
    end
    enable = 1'b1;
    value = 16'h9A5C; dp = 4'b0010; load = 1'b1;
    cycles(40);

    // Reset mid-slot during DRIVE.
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      step();
      if (m_active && (m_t % RD) >= BC) found = 1'b1;
    end
    check("wait_drive", {7'h0, found}, 8'h01);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_an", {4'h0, an}, 8'h0F);
    check("midrst_out", out, 8'hFF);
    check("midrst_fs", {7'h0, frame_start}, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check("post_rst_out", out, 8'hC0);
    cycles(40);
    value = 16'h4567; dp = 4'h0; load = 1'b1;
    cycles(40);

    // Leading-zero case (expectations depend on build macro).
    value = 16'h0007; dp = 4'b0100; load = 1'b1;
    cycles(70);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
